// File: rtl/apb2mem.sv
// apb2mem: APB4 completer bridging to a native valid/ready memory port with window decode and timeout.
// Rev 1.0
`default_nettype none

module apb2mem #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] WIN_SIZE       = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] apb_paddr_i,
  input  logic [2:0]  apb_pprot_i,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  input  logic [3:0]  apb_pstrb_i,
  output logic        apb_pready_o,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pslverr_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_write;

  logic        w_setup;
  logic [31:0] w_off;
  logic        w_inwin;
  logic        w_zero_wr;
  logic        w_unused;

  assign w_setup   = apb_psel_i & ~apb_penable_i;
  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign w_off     = apb_paddr_i - BASE_ADDR;
  assign w_inwin   = (w_off < WIN_SIZE);
  assign w_zero_wr = apb_pwrite_i & (apb_pstrb_i == 4'h0);
  assign w_unused  = ^apb_pprot_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_write       <= 1'b0;
      apb_pready_o  <= 1'b0;
      apb_prdata_o  <= 32'h0;
      apb_pslverr_o <= 1'b0;
      mem_valid_o   <= 1'b0;
      mem_addr_o    <= 32'h0;
      mem_wdata_o   <= 32'h0;
      mem_wstrb_o   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          apb_pready_o  <= 1'b0;
          apb_pslverr_o <= 1'b0;
          apb_prdata_o  <= 32'h0;
          if (w_setup) begin
            mem_addr_o  <= {apb_paddr_i[31:2], 2'b00};
            mem_wdata_o <= apb_pwdata_i;
            mem_wstrb_o <= apb_pwrite_i ? apb_pstrb_i : 4'h0;
            r_write     <= apb_pwrite_i;
            r_cnt       <= 8'd1;
            if (!w_inwin) begin
              r_state       <= S_RESP;
              apb_pready_o  <= 1'b1;
              apb_pslverr_o <= 1'b1;
            end else if (w_zero_wr) begin
              r_state      <= S_RESP;
              apb_pready_o <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              mem_valid_o <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (!apb_psel_i) begin
            r_state     <= S_IDLE;
            mem_valid_o <= 1'b0;
            r_cnt       <= 8'd0;
          end else if (mem_ready_i) begin
            // Ready on the final counted cycle still wins over the timeout.
            r_state      <= S_RESP;
            mem_valid_o  <= 1'b0;
            apb_pready_o <= 1'b1;
            apb_prdata_o <= r_write ? 32'h0 : mem_rdata_i;
            r_cnt        <= 8'd0;
          end else if (r_cnt == C_TIMEOUT) begin
            r_state       <= S_RESP;
            mem_valid_o   <= 1'b0;
            apb_pready_o  <= 1'b1;
            apb_pslverr_o <= 1'b1;
            r_cnt         <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP: begin
          r_state       <= S_IDLE;
          apb_pready_o  <= 1'b0;
          apb_pslverr_o <= 1'b0;
          apb_prdata_o  <= 32'h0;
        end

        default: begin
          r_state       <= S_IDLE;
          mem_valid_o   <= 1'b0;
          apb_pready_o  <= 1'b0;
          apb_pslverr_o <= 1'b0;
          apb_prdata_o  <= 32'h0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
